gnrc_fifo_lvl: RTL and testbench
================================

Name: gnrc_fifo_lvl

Overview:
Second-generation generic synchronous FIFO for the connect library. It supports arbitrary (non-power-of-2) depth and a selectable output mode: registered read or first-word-fall-through. It also provides a fill-level count, run-time programmable almost-full/almost-empty thresholds and a synchronous flush. It is a drop-in buffer between streaming producers and consumers in one clock domain.

Parameters:
DW, 16, data width in bits (>=1)
DP, 13, depth in entries (>=2, any integer, not restricted to powers of 2)
FWFT, 0, 0 = registered read (data one cycle after read accept); 1 = first-word-fall-through
CW, $clog2(DP+1), width of level/threshold signals (derived, not overridden)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
flush_i  input  1  synchronous clear of contents
data_i  input  DW  write data
wen_i  input  1  write request
ren_i  input  1  read request
afull_th_i  input  CW  almost-full threshold
aempty_th_i  input  CW  almost-empty threshold
data_o  output  DW  read data
rvalid_o  output  1  data_o valid (FWFT=0: read-data strobe; FWFT=1: equals ~empty_o)
full_o  output  1  count == DP
empty_o  output  1  count == 0
afull_o  output  1  count >= afull_th_i
aempty_o  output  1  count <= aempty_th_i
level_o  output  CW  current entry count, 0..DP
ovf_o  output  1  sticky overflow flag (optional feature)
udf_o  output  1  sticky underflow flag (optional feature)

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Storage: DP x DW register array; write pointer wptr and read pointer rptr, each 0..DP-1. Each pointer wraps from DP-1 to 0 (explicit compare, not modulo-2^n). A separate count register holds 0..DP.
- Write accept: wen_i & ~full_o. On accept, mem[wptr] <= data_i and wptr advances. A write while full is dropped; the array is unchanged.
- Read accept: ren_i & ~empty_o. On accept, rptr advances. A read while empty is ignored.
- Simultaneous accepted write and read: count unchanged; both pointers advance.
- Count: +1 on write-only, -1 on read-only, held otherwise. level_o = count.
- full_o, empty_o, afull_o and aempty_o are combinational from the count register and threshold inputs. Thresholds may change at any time; the flags follow the same cycle.
- FWFT=0:
  - data_o is registered and loads mem[rptr] on read accept.
  - rvalid_o is 1 in the cycle after each read accept, otherwise 0.
  - data_o holds its last value when no read occurs.
- FWFT=1:
  - data_o = mem[rptr] combinationally; rvalid_o = ~empty_o.
  - A write into an empty FIFO is visible on data_o the next cycle, not the same cycle.
- Flush:
  - flush_i high clears wptr, rptr and count at the next edge; rvalid_o <= 0.
  - Flush has priority over a write or read in the same cycle; that write is discarded.
  - Array contents need not be cleared.
  - Outputs the cycle after a flush: empty_o=1, full_o=0, level_o=0.
- Reset: rst_i overrides flush and all accesses. Reset values: pointers=0, count=0, data_o=0, rvalid_o=0, ovf_o=0, udf_o=0. Hence empty_o=1, full_o=0, level_o=0; afull_o/aempty_o follow the thresholds against count 0.
- Reset mid-operation: state is cleared at the edge; in-flight data is lost; no partial read strobe.

Optional Feature:
GNRC_FIFO_ERR_EN
- Defined:
  - ovf_o sets on wen_i & full_o.
  - udf_o sets on ren_i & empty_o.
  - Both are sticky until rst_i or flush_i.
  - When flush_i and an offending access occur in the same cycle, the flag is cleared, not set.
- Not defined: ovf_o and udf_o are tied to 0; the ports remain, so benches bind unchanged.

Test Plan:
1. Fill (DP=13, FWFT=0): after reset, assert wen_i with data 1..14, ren_i=0 -> full_o=1 after the 13th accept; level_o=13; the 14th write is dropped; with ERR_EN, ovf_o=1.
2. Drain: from case 1, ren_i=1 for 14 cycles -> data_o=1..13 with rvalid_o one cycle after each accept; empty_o=1 after the 13th; the 14th read is ignored; with ERR_EN, udf_o=1.
3. Wrap (DP=13): hold level 5 and run wen_i=ren_i=1 for 40 cycles on an incrementing stream -> level_o constant at 5; output sequence strictly increasing with no gaps across pointer wrap 12->0.
4. Flush priority: at level 7, assert flush_i with wen_i=ren_i=1 for one cycle -> next cycle level_o=0, empty_o=1, rvalid_o=0, ovf_o/udf_o=0; a subsequent read returns only data written after the flush.
5. Thresholds: afull_th_i=10, aempty_th_i=2, write-only from empty -> aempty_o drops when level_o goes 2->3; afull_o rises at level 10. Changing afull_th_i to 12 at level 10 -> afull_o=0 the same cycle.
6. FWFT=1 and reset: write 0xA5A5 into an empty FIFO -> next cycle data_o=0xA5A5 and rvalid_o=1 with no read. Then assert rst_i at level 4 -> next cycle level_o=0, empty_o=1, data_o=mem[0] (don't-care), rvalid_o=0.

Source files
------------

// File: rtl/gnrc_fifo_lvl_if.sv
// Handshake bundle for gnrc_fifo_lvl: write/read requests,
// flush, thresholds and status/level outputs.
interface gnrc_fifo_lvl_if #(
  parameter int DW = 16,
  parameter int DP = 13
);
  localparam int CW = $clog2(DP + 1);

  logic          flush_i;
  logic [DW-1:0] data_i;
  logic          wen_i;
  logic          ren_i;
  logic [CW-1:0] afull_th_i;
  logic [CW-1:0] aempty_th_i;
  logic [DW-1:0] data_o;
  logic          rvalid_o;
  logic          full_o;
  logic          empty_o;
  logic          afull_o;
  logic          aempty_o;
  logic [CW-1:0] level_o;
  logic          ovf_o;
  logic          udf_o;

  modport slave (
    input  flush_i, data_i, wen_i, ren_i,
    input  afull_th_i, aempty_th_i,
    output data_o, rvalid_o, full_o, empty_o,
    output afull_o, aempty_o, level_o,
    output ovf_o, udf_o
  );

  modport master (
    output flush_i, data_i, wen_i, ren_i,
    output afull_th_i, aempty_th_i,
    input  data_o, rvalid_o, full_o, empty_o,
    input  afull_o, aempty_o, level_o,
    input  ovf_o, udf_o
  );
endinterface

// File: rtl/gnrc_fifo_lvl.sv
// Generic sync FIFO, any depth, registered or FWFT read.
// Define GNRC_FIFO_ERR_EN for sticky ovf/udf flags.
module gnrc_fifo_lvl #(
  parameter int DW   = 16,
  parameter int DP   = 13,
  parameter int FWFT = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  gnrc_fifo_lvl_if.slave  io
);
  localparam int CW = $clog2(DP + 1);
  localparam int PW = $clog2(DP);
  localparam logic [CW-1:0] DP_C = CW'(DP);
  localparam logic [PW-1:0] LAST = PW'(DP - 1);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  always_comb begin
    full   = (cnt_q == DP_C);
    empty  = (cnt_q == '0);
    wr_acc = io.wen_i & ~full;
    rd_acc = io.ren_i & ~empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (io.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      // explicit wrap: depth need not be a power of two
      if (wr_acc)
        wptr_d = (wptr_q == LAST) ? '0 : wptr_q + PW'(1);
      if (rd_acc)
        rptr_d = (rptr_q == LAST) ? '0 : rptr_q + PW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc & ~io.flush_i & ~rst_i)
      mem_q[wptr_q] <= io.data_i;
  end

  assign io.full_o   = full;
  assign io.empty_o  = empty;
  assign io.level_o  = cnt_q;
  assign io.afull_o  = (cnt_q >= io.afull_th_i);
  assign io.aempty_o = (cnt_q <= io.aempty_th_i);

  if (FWFT == 0) begin : g_reg
    logic [DW-1:0] dout_q, dout_d;
    logic          rv_q, rv_d;

    always_comb begin
      dout_d = dout_q;
      rv_d   = 1'b0;
      if (rd_acc & ~io.flush_i) begin
        dout_d = mem_q[rptr_q];
        rv_d   = 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        dout_q <= dout_d;
        rv_q   <= rv_d;
      end
    end

    assign io.data_o   = dout_q;
    assign io.rvalid_o = rv_q;
  end else begin : g_fwft
    assign io.data_o   = mem_q[rptr_q];
    assign io.rvalid_o = ~empty;
  end

`ifdef GNRC_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // flush wins over an offending access in the same cycle
  always_comb begin
    ovf_d = ovf_q | (io.wen_i & full);
    udf_d = udf_q | (io.ren_i & empty);
    if (io.flush_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign io.ovf_o = ovf_q;
  assign io.udf_o = udf_q;
`else
  assign io.ovf_o = 1'b0;
  assign io.udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_gnrc_fifo_lvl.sv
// Bench for gnrc_fifo_lvl: registered and FWFT instances
// driven in lockstep and checked against a queue model.
module tb_gnrc_fifo_lvl;
  localparam int DW = 16;
  localparam int DP = 13;

  logic        clk = 1'b0;
  logic        rst, flush, wen, ren;
  logic [15:0] din;
  logic [3:0]  afth, aeth;

  int npass = 0;
  int ntot  = 0;

  logic [15:0] q[$];
  logic [15:0] m_dout;
  logic        m_rv, m_ovf, m_udf;

  always #5 clk = ~clk;

  gnrc_fifo_lvl_if #(.DW(DW), .DP(DP)) if0 ();
  gnrc_fifo_lvl_if #(.DW(DW), .DP(DP)) if1 ();

  assign if0.flush_i     = flush;
  assign if0.data_i      = din;
  assign if0.wen_i       = wen;
  assign if0.ren_i       = ren;
  assign if0.afull_th_i  = afth;
  assign if0.aempty_th_i = aeth;
  assign if1.flush_i     = flush;
  assign if1.data_i      = din;
  assign if1.wen_i       = wen;
  assign if1.ren_i       = ren;
  assign if1.afull_th_i  = afth;
  assign if1.aempty_th_i = aeth;

  gnrc_fifo_lvl #(.DW(DW), .DP(DP), .FWFT(0)) u_reg (
    .clk_i (clk),
    .rst_i (rst),
    .io    (if0)
  );

  gnrc_fifo_lvl #(.DW(DW), .DP(DP), .FWFT(1)) u_fwft (
    .clk_i (clk),
    .rst_i (rst),
    .io    (if1)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h t=%0t",
                  nm, act, exp, $time);
  endtask

  // Model: state advanced from the inputs seen at an edge.
  task automatic model_step();
    bit f, e;
    f = (q.size() == DP);
    e = (q.size() == 0);
    if (rst) begin
      q.delete();
      m_dout = '0;
      m_rv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (flush) begin
      q.delete();
      m_rv  = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_rv = ren && !e;
      if (ren && !e) m_dout = q.pop_front();
      if (wen && !f) q.push_back(din);
`ifdef GNRC_FIFO_ERR_EN
      if (wen && f) m_ovf = 1'b1;
      if (ren && e) m_udf = 1'b1;
`endif
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("r.level",  32'(if0.level_o),  32'(sz));
    chk("r.full",   32'(if0.full_o),   32'(sz == DP));
    chk("r.empty",  32'(if0.empty_o),  32'(sz == 0));
    chk("r.afull",  32'(if0.afull_o),  32'(sz >= int'(afth)));
    chk("r.aempty", 32'(if0.aempty_o), 32'(sz <= int'(aeth)));
    chk("r.ovf",    32'(if0.ovf_o),    32'(m_ovf));
    chk("r.udf",    32'(if0.udf_o),    32'(m_udf));
    chk("r.rvalid", 32'(if0.rvalid_o), 32'(m_rv));
    chk("r.data",   32'(if0.data_o),   32'(m_dout));
    chk("f.level",  32'(if1.level_o),  32'(sz));
    chk("f.full",   32'(if1.full_o),   32'(sz == DP));
    chk("f.empty",  32'(if1.empty_o),  32'(sz == 0));
    chk("f.afull",  32'(if1.afull_o),  32'(sz >= int'(afth)));
    chk("f.aempty", 32'(if1.aempty_o), 32'(sz <= int'(aeth)));
    chk("f.ovf",    32'(if1.ovf_o),    32'(m_ovf));
    chk("f.udf",    32'(if1.udf_o),    32'(m_udf));
    chk("f.rvalid", 32'(if1.rvalid_o), 32'(sz != 0));
    if (sz != 0)
      chk("f.data", 32'(if1.data_o), 32'(q[0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(logic r, logic fl, logic w,
                       logic rd, logic [15:0] d);
    rst = r; flush = fl; wen = w; ren = rd; din = d;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        r, fl, w, rd;
    logic [15:0] d;
    logic [3:0]  lv;
    logic        e, f, rv;
    logic [15:0] dq;
  } vec_t;

  vec_t vt[11];

  initial begin
    int nxt, exp_rd;
    int bias;
    drive(1, 0, 0, 0, 0);
    afth = 4'd10;
    aeth = 4'd2;
    m_dout = '0; m_rv = 0; m_ovf = 0; m_udf = 0;

    vt[0]  = '{1,0,0,0,16'h0000, 0,1,0,0,16'h0000};
    vt[1]  = '{0,0,1,0,16'h0011, 1,0,0,0,16'h0000};
    vt[2]  = '{0,0,1,0,16'h0022, 2,0,0,0,16'h0000};
    vt[3]  = '{0,0,1,1,16'h0033, 2,0,0,1,16'h0011};
    vt[4]  = '{0,0,0,1,16'h0000, 1,0,0,1,16'h0022};
    vt[5]  = '{0,0,0,0,16'h0000, 1,0,0,0,16'h0022};
    vt[6]  = '{0,1,1,1,16'h0044, 0,1,0,0,16'h0022};
    vt[7]  = '{0,0,0,1,16'h0000, 0,1,0,0,16'h0022};
    vt[8]  = '{0,0,1,0,16'h0055, 1,0,0,0,16'h0022};
    vt[9]  = '{0,0,0,1,16'h0000, 0,1,0,1,16'h0055};
    vt[10] = '{1,0,1,0,16'h0066, 0,1,0,0,16'h0000};

    for (int i = 0; i < 11; i++) begin
      drive(vt[i].r, vt[i].fl, vt[i].w, vt[i].rd, vt[i].d);
      cyc();
      chk($sformatf("vec%0d.level", i),
          32'(if0.level_o), 32'(vt[i].lv));
      chk($sformatf("vec%0d.empty", i),
          32'(if0.empty_o), 32'(vt[i].e));
      chk($sformatf("vec%0d.full", i),
          32'(if0.full_o), 32'(vt[i].f));
      chk($sformatf("vec%0d.rvalid", i),
          32'(if0.rvalid_o), 32'(vt[i].rv));
      chk($sformatf("vec%0d.data", i),
          32'(if0.data_o), 32'(vt[i].dq));
    end

    // fill past full, then drain past empty
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      drive(0, 0, 1, 0, 16'(i));
      cyc();
      if (i == 13) chk("fill.full13", 32'(if0.full_o), 1);
    end
    chk("fill.level", 32'(if0.level_o), 13);
`ifdef GNRC_FIFO_ERR_EN
    chk("fill.ovf", 32'(if0.ovf_o), 1);
`endif
    for (int i = 1; i <= 14; i++) begin
      drive(0, 0, 0, 1, 0);
      cyc();
      if (i <= 13) begin
        chk("drain.rv", 32'(if0.rvalid_o), 1);
        chk("drain.data", 32'(if0.data_o), 32'(i));
      end else begin
        chk("drain.rv14", 32'(if0.rvalid_o), 0);
      end
    end
    chk("drain.empty", 32'(if0.empty_o), 1);
`ifdef GNRC_FIFO_ERR_EN
    chk("drain.udf", 32'(if0.udf_o), 1);
`endif

    // steady level 5 across many pointer wraps
    do_reset();
    nxt = 0;
    exp_rd = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 0, 16'(nxt)); nxt++;
      cyc();
    end
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 1, 1, 16'(nxt)); nxt++;
      cyc();
      chk("wrap.level", 32'(if0.level_o), 5);
      chk("wrap.data", 32'(if0.data_o), 32'(exp_rd));
      exp_rd++;
    end

    // flush beats simultaneous write and read
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 0, 16'(16'h100 + i));
      cyc();
    end
    drive(0, 1, 1, 1, 16'hDEAD);
    cyc();
    chk("flush.level", 32'(if0.level_o), 0);
    chk("flush.empty", 32'(if0.empty_o), 1);
    chk("flush.rv", 32'(if0.rvalid_o), 0);
    chk("flush.ovf", 32'(if0.ovf_o), 0);
    chk("flush.udf", 32'(if0.udf_o), 0);
    drive(0, 0, 1, 0, 16'h0777);
    cyc();
    drive(0, 0, 0, 1, 0);
    cyc();
    chk("flush.rd", 32'(if0.data_o), 32'h0777);

    // thresholds, including a same-cycle change
    do_reset();
    afth = 4'd10;
    aeth = 4'd2;
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 1, 0, 16'(i));
      cyc();
      chk("th.aempty", 32'(if0.aempty_o), 32'(i <= 2));
      chk("th.afull", 32'(if0.afull_o), 32'(i >= 10));
    end
    drive(0, 0, 0, 0, 0);
    afth = 4'd12;
    #1;
    chk("th.afull12", 32'(if0.afull_o), 0);
    check_all();

    // FWFT visibility and reset mid-operation
    do_reset();
    drive(0, 0, 1, 0, 16'hA5A5);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("fwft.data", 32'(if1.data_o), 32'hA5A5);
    chk("fwft.rv", 32'(if1.rvalid_o), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 16'(i));
      cyc();
    end
    chk("fwft.lvl4", 32'(if1.level_o), 4);
    drive(0, 0, 1, 1, 16'h1234);
    cyc();
    drive(1, 0, 1, 1, 16'h4321);
    cyc();
    chk("rst.level", 32'(if1.level_o), 0);
    chk("rst.empty", 32'(if1.empty_o), 1);
    chk("rst.rv", 32'(if1.rvalid_o), 0);
    chk("rst.rv0", 32'(if0.rvalid_o), 0);
    chk("rst.data0", 32'(if0.data_o), 0);

    // random traffic against the model
    drive(0, 0, 0, 0, 0);
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(15, 85);
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 59) == 0);
      wen   = ($urandom_range(0, 99) < bias);
      ren   = ($urandom_range(0, 99) >= bias);
      din   = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        afth = 4'($urandom_range(0, 15));
        aeth = 4'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
